// File: rtl/branch_cmp_pkg.sv
// Shared encodings for the branch compare unit: RISC-V funct3 branch ops,
// FSM states and the op-to-decision helpers.
package branch_cmp_pkg;

  typedef enum logic [2:0] {
    OP_BEQ  = 3'b000,
    OP_BNE  = 3'b001,
    OP_BLT  = 3'b100,
    OP_BGE  = 3'b101,
    OP_BLTU = 3'b110,
    OP_BGEU = 3'b111
  } br_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } cmp_state_e;

  // 010 and 011 are unused funct3 codes in the branch space
  function automatic logic is_op_err(input logic [2:0] op);
    return (op == 3'b010) || (op == 3'b011);
  endfunction

  function automatic logic branch_taken(input logic [2:0] op,
                                        input logic       eq,
                                        input logic       lt_s,
                                        input logic       lt_u);
    logic t;
    t = 1'b0;
    case (op)
      OP_BEQ:  t = eq;
      OP_BNE:  t = !eq;
      OP_BLT:  t = lt_s;
      OP_BGE:  t = !lt_s;
      OP_BLTU: t = lt_u;
      OP_BGEU: t = !lt_u;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/chunk_cmp.sv
// Combinational unsigned comparator for one operand chunk.
module chunk_cmp #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq,
  output logic         lt
);

  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/branch_compare_unit.sv
// Multi-cycle branch comparator: scans operands one chunk per cycle from the
// MSB end and stops at the first differing chunk.
//
// state | meaning
// IDLE  | ready for a request, in_ready=1
// SCAN  | comparing chunk idx, moving toward LSB while chunks match
// DONE  | result held on outputs until out_ready
module branch_compare_unit
  import branch_cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic             eq,
  output logic             lt_s,
  output logic             lt_u,
  output logic             op_err
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

  if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
    $error("branch_compare_unit: WIDTH must be a multiple of CHUNK");
  end

  cmp_state_e       state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [2:0]       op_r;
  logic [IDX_W-1:0] idx;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic             chunk_eq;
  logic             chunk_lt;
  logic             fin_lt_s;

  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx == IDX_W'(i)) begin
        a_chunk = a_r[i*CHUNK +: CHUNK];
        b_chunk = b_r[i*CHUNK +: CHUNK];
      end
    end
  end

  chunk_cmp #(.W(CHUNK)) u_chunk_cmp (
    .a  (a_chunk),
    .b  (b_chunk),
    .eq (chunk_eq),
    .lt (chunk_lt)
  );

  // Sign bits decide when they differ; otherwise signed order equals unsigned.
  // chunk_lt is 0 on the final all-equal chunk, so it doubles as lt_u there.
  assign fin_lt_s = (a_r[WIDTH-1] != b_r[WIDTH-1]) ? a_r[WIDTH-1] : chunk_lt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      taken     <= 1'b0;
      eq        <= 1'b0;
      lt_s      <= 1'b0;
      lt_u      <= 1'b0;
      op_err    <= 1'b0;
      idx       <= IDX_TOP;
      a_r       <= '0;
      b_r       <= '0;
      op_r      <= '0;
    end else if (flush) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      idx       <= IDX_TOP;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            op_r     <= op;
            idx      <= IDX_TOP;
            in_ready <= 1'b0;
            state    <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (chunk_eq && (idx != '0)) begin
            idx <= idx - IDX_W'(1);
          end else begin
            eq        <= chunk_eq;
            lt_u      <= chunk_lt;
            lt_s      <= fin_lt_s;
            taken     <= branch_taken(op_r, chunk_eq, fin_lt_s, chunk_lt);
            op_err    <= is_op_err(op_r);
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            idx       <= IDX_TOP;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          idx       <= IDX_TOP;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_compare_unit.sv
// Scoreboard bench for branch_compare_unit: directed corner cases followed by
// randomized requests with random backpressure and flushes.
module tb_branch_compare_unit;

  localparam int W  = 32;
  localparam int C  = 8;
  localparam int NC = W / C;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic         taken;
  logic         eq;
  logic         lt_s;
  logic         lt_u;
  logic         op_err;

  branch_compare_unit #(.WIDTH(W), .CHUNK(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .taken     (taken),
    .eq        (eq),
    .lt_s      (lt_s),
    .lt_u      (lt_u),
    .op_err    (op_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] res;     // {taken, eq, lt_s, lt_u, op_err}
    int         lat;
    int         accept;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   hold_cnt = 0;
  bit   rand_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, expv, cyc);
    end
  endtask

  // Reference: plain arithmetic on whole operands; latency from the first
  // MSB-side prefix of chunks that differs.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic [2:0] o, input int acc);
    exp_t e;
    int   k;
    logic m_eq, m_ls, m_lu, t, err;
    m_eq = (x == y);
    m_lu = (x < y);
    m_ls = ($signed(x) < $signed(y));
    k = 0;
    for (int i = 1; i <= NC; i++)
      if (k == 0 && ((x >> (W - i*C)) != (y >> (W - i*C)))) k = i;
    if (k == 0) k = NC;
    case (o)
      3'b000:  t = m_eq;
      3'b001:  t = !m_eq;
      3'b100:  t = m_ls;
      3'b101:  t = !m_ls;
      3'b110:  t = m_lu;
      3'b111:  t = !m_lu;
      default: t = 1'b0;
    endcase
    err = (o == 3'b010) || (o == 3'b011);
    e.res = {t, m_eq, m_ls, m_lu, err};
    e.lat = k + 1;
    e.accept = acc;
    return e;
  endfunction

  // Monitor: samples on the falling edge, away from DUT updates.
  bit         ov_prev = 1'b0;
  logic [4:0] snap = '0;

  always @(negedge clk) begin
    if (rst) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid && !ov_prev) begin
        chk("result_pending", 64'(sb.size()), 64'd1);
        if (sb.size() != 0) begin
          chk("result", 64'({taken, eq, lt_s, lt_u, op_err}), 64'(sb[0].res));
          chk("latency", 64'(cyc + 1 - sb[0].accept), 64'(sb[0].lat));
        end
        snap = {taken, eq, lt_s, lt_u, op_err};
      end else if (out_valid && ov_prev) begin
        chk("hold_stable", 64'({taken, eq, lt_s, lt_u, op_err}), 64'(snap));
      end
      if (out_valid) chk("in_ready_done", 64'(in_ready), 64'd0);
      if (out_valid && out_ready && !flush && sb.size() != 0) sb.delete(0);
      ov_prev = out_valid && !out_ready && !flush;
    end
  end

  // Result sink: random or forced-high ready, with an optional initial hold.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (out_valid && hold_cnt > 0) begin
        out_ready = 1'b0;
        hold_cnt--;
      end else begin
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [2:0] o, input bit allow_flush);
    int n;
    a = x; b = y; op = o; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin step(); n++; end
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    sb.push_back(model(x, y, o, cyc + 1));
    step();
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op = 3'($urandom);
    if (allow_flush && $urandom_range(0, 7) == 0) begin
      repeat ($urandom_range(0, 3)) step();
      if (sb.size() != 0 && !out_valid) begin
        flush = 1'b1;
        sb.delete(0);
        step();
        flush = 1'b0;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] x, y;
    int n;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    a = '0; b = '0; op = '0;
    repeat (3) step();
    chk("reset_state", 64'({in_ready, out_valid, taken, eq, lt_s, lt_u, op_err}), 64'b1000000);
    rst = 1'b0;
    step();

    send(32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 1'b0);
    send(32'h1234_5678, 32'h1234_5678, 3'b000, 1'b0);
    send(32'h1234_5678, 32'h1234_5678, 3'b001, 1'b0);
    hold_cnt = 3;
    send(32'h0000_0005, 32'h0000_0006, 3'b111, 1'b0);
    send($urandom, $urandom, 3'b010, 1'b0);
    send(32'h8000_0000, 32'h7FFF_FFFF, 3'b011, 1'b0);
    send(32'h8000_0000, 32'h7FFF_FFFF, 3'b101, 1'b0);
    send(32'h8000_0000, 32'h7FFF_FFFF, 3'b110, 1'b0);

    // Reset during the scan: operation must vanish without a result.
    send(32'h0001_0000, 32'h0002_0000, 3'b100, 1'b0);
    step();
    rst = 1'b1;
    sb.delete();
    step();
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_outputs", 64'({taken, eq, lt_s, lt_u, op_err}), 64'd0);
    repeat (6) step();

    // Flush together with out_ready in DONE drops the result.
    hold_cnt = 2;
    send(32'hDEAD_BEEF, 32'hDEAD_0000, 3'b001, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin step(); n++; end
    chk("flush_done_reached", 64'(out_valid), 64'd1);
    step();
    step();
    flush = 1'b1;
    sb.delete();
    step();
    flush = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    repeat (4) step();
    send(32'h0000_0010, 32'hFFFF_FFF0, 3'b100, 1'b0);

    rand_ready = 1'b1;
    for (int t = 0; t < 150; t++) begin
      x = $urandom;
      y = x;
      case ($urandom_range(0, 3))
        0:       y = $urandom;
        1:       y = x;
        default: y[8*$urandom_range(0, 3) +: 8] = 8'($urandom);
      endcase
      send(x, y, 3'($urandom), 1'b1);
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin step(); n++; end
    chk("drain", 64'(sb.size()), 64'd0);
    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
